// File: rtl/ddr3_ring_sched_pkg.sv
// Shared definitions for the DDR3 ring scheduler: FSM encoding and address math.
// Pure declarations; no timing of its own.
// Not applicable (no handshakes live here).
package ddr3_ring_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // Bytes moved by one burst.
  function automatic int burst_bytes(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

  // Byte address where channel ch's ring region begins.
  function automatic logic [63:0] region_base(input logic [1:0] ch, input int region_log2,
                                              input int bb);
    return (64'(ch) << region_log2) * 64'(bb);
  endfunction

endpackage

// File: rtl/ddr3_ring_sched_if.sv
// Burst-engine command bus between the scheduler (master) and the shared burst engine (slave).
// Wires only; no latency.
// The engine holds off the scheduler simply by not pulsing burst_done_i.
interface ddr3_ring_sched_if #(
  parameter int ADDR_WIDTH = 31
) ();
  logic                  burst_start_o;
  logic                  burst_wr_o;
  logic [1:0]            burst_ch_o;
  logic [ADDR_WIDTH-1:0] burst_addr_o;
  logic                  burst_done_i;

  modport master (
    output burst_start_o, burst_wr_o, burst_ch_o, burst_addr_o,
    input  burst_done_i
  );

  modport slave (
    input  burst_start_o, burst_wr_o, burst_ch_o, burst_addr_o,
    output burst_done_i
  );
endinterface

// File: rtl/ddr3_ring_sched_rr_arb4.sv
// Four-way round-robin selector: searches from last+1 upward (mod 4) for the first request.
// Purely combinational, zero latency.
// No backpressure; vld low means no request is pending.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       vld
);

  // Walk the candidates farthest-first so the nearest one after last overwrites the result.
  always_comb begin
    logic [1:0] idx;
    grant = last;
    vld   = 1'b0;
    idx   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        grant = idx;
        vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_ring_sched.sv
// Schedules per-channel write/read bursts between stream FIFOs and DDR3 ring regions.
// Eligible request in IDLE -> burst_start_o two cycles later (ARB, ISSUE); one burst in flight.
// Waits in WAIT for burst_done_i; channels are eligible only when their FIFO and ring allow.
module ddr3_ring_sched
  import ddr3_ring_sched_pkg::*;
#(
  parameter int CHANNEL_NUM        = 4,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 31,
  parameter int REGION_LOG2        = 19
) (
  input  logic                                  sys_clk_i,
  input  logic                                  rst_i,
  input  logic                                  phy_init_done,
  input  logic [CHANNEL_NUM-1:0]                us_ready_i,
  input  logic [CHANNEL_NUM-1:0]                ds_ready_i,
  ddr3_ring_sched_if.master                     bus,
  output logic [CHANNEL_NUM*(REGION_LOG2+1)-1:0] ring_count_o,
  output logic                                  busy_o
);

  localparam int PW = REGION_LOG2 + 1;
  localparam int BB = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {REGION_LOG2{1'b0}}};

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr [4];
  logic [PW-1:0]   rd_ptr [4];
  logic [PW-1:0]   count  [4];
  logic [3:0]      wr_elig, rd_elig;
  logic            last_dir_wr;
  logic [1:0]      last_win_wr, last_win_rd;
  logic [1:0]      gnt_wr, gnt_rd;
  logic            vld_wr, vld_rd;
  logic            sel_wr;
  logic [1:0]      sel_ch;
  logic [PW-1:0]   sel_ptr;
  logic [63:0]     sel_addr;

  // Ring occupancy and per-channel eligibility from the live pointers.
  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int c = 0; c < 4; c++) begin
      count[c]   = wr_ptr[c] - rd_ptr[c];
      wr_elig[c] = us_ready_i[c] && (count[c] != FULL_CNT);
      rd_elig[c] = ds_ready_i[c] && (count[c] != '0);
    end
  end

  rr_arb4 u_arb_wr (.req(wr_elig), .last(last_win_wr), .grant(gnt_wr), .vld(vld_wr));
  rr_arb4 u_arb_rd (.req(rd_elig), .last(last_win_rd), .grant(gnt_rd), .vld(vld_rd));

  // Direction pick (alternate when both directions compete) and the resulting byte address.
  always_comb begin
    sel_wr   = vld_wr && (!vld_rd || !last_dir_wr);
    sel_ch   = sel_wr ? gnt_wr : gnt_rd;
    sel_ptr  = sel_wr ? wr_ptr[sel_ch] : rd_ptr[sel_ch];
    sel_addr = region_base(sel_ch, REGION_LOG2, BB)
             + 64'(sel_ptr[REGION_LOG2-1:0]) * 64'(BB);
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_nxt         = state;
    bus.burst_start_o = 1'b0;
    busy_o            = 1'b1;
    case (state)
      ST_INIT: begin
        busy_o = 1'b0;
        if (phy_init_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        busy_o = 1'b0;
        if (|wr_elig || |rd_elig) state_nxt = ST_ARB;
      end
      ST_ARB:   state_nxt = (vld_wr || vld_rd) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        bus.burst_start_o = 1'b1;
        state_nxt         = ST_WAIT;
      end
      ST_WAIT:  if (bus.burst_done_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Latch the winning burst in ARB; it stays put until the next ARB.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.burst_wr_o   <= 1'b0;
      bus.burst_ch_o   <= 2'd0;
      bus.burst_addr_o <= '0;
      last_dir_wr      <= 1'b0;
      last_win_wr      <= 2'd3;
      last_win_rd      <= 2'd3;
    end else if (state == ST_ARB && (vld_wr || vld_rd)) begin
      bus.burst_wr_o   <= sel_wr;
      bus.burst_ch_o   <= sel_ch;
      bus.burst_addr_o <= sel_addr[C_M_AXI_ADDR_WIDTH-1:0];
      last_dir_wr      <= sel_wr;
      if (sel_wr) last_win_wr <= gnt_wr;
      else        last_win_rd <= gnt_rd;
    end
  end

  // Advance the owning pointer when the engine reports completion.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < 4; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else if (state == ST_WAIT && bus.burst_done_i) begin
      if (bus.burst_wr_o) wr_ptr[bus.burst_ch_o] <= wr_ptr[bus.burst_ch_o] + PW'(1);
      else                rd_ptr[bus.burst_ch_o] <= rd_ptr[bus.burst_ch_o] + PW'(1);
    end
  end

  // Registered copy of the occupancies, one cycle behind the pointers.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) ring_count_o <= '0;
    else
      for (int c = 0; c < 4; c++) ring_count_o[c*PW +: PW] <= count[c];
  end

endmodule

// File: tb/tb_ddr3_ring_sched.sv
// Directed bench for ddr3_ring_sched: a default instance and a REGION_LOG2=2 instance for wrap/full.
// Inputs driven and outputs sampled on the falling clock edge.
// The bench plays the burst engine, pulsing burst_done_i one cycle into WAIT.
module tb_ddr3_ring_sched;

  localparam int AW = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        phy;
  logic [3:0]  us, ds, us_s, ds_s;
  logic [79:0] rc;
  logic [11:0] rc_s;
  logic        busy, busy_s;
  int          checks   = 0;
  int          failures = 0;
  int          cnt;
  int          lat;

  ddr3_ring_sched_if #(.ADDR_WIDTH(AW)) bus ();
  ddr3_ring_sched_if #(.ADDR_WIDTH(AW)) bus_s ();

  ddr3_ring_sched dut (
    .sys_clk_i(clk), .rst_i(rst), .phy_init_done(phy),
    .us_ready_i(us), .ds_ready_i(ds), .bus(bus),
    .ring_count_o(rc), .busy_o(busy)
  );

  ddr3_ring_sched #(.REGION_LOG2(2)) dut_s (
    .sys_clk_i(clk), .rst_i(rst), .phy_init_done(phy),
    .us_ready_i(us_s), .ds_ready_i(ds_s), .bus(bus_s),
    .ring_count_o(rc_s), .busy_o(busy_s)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_start(input bit s);
    return s ? bus_s.burst_start_o : bus.burst_start_o;
  endfunction

  function automatic logic [63:0] cur_addr(input bit s);
    return s ? 64'(bus_s.burst_addr_o) : 64'(bus.burst_addr_o);
  endfunction

  function automatic logic [63:0] cur_wr(input bit s);
    return s ? 64'(bus_s.burst_wr_o) : 64'(bus.burst_wr_o);
  endfunction

  function automatic logic [63:0] cur_ch(input bit s);
    return s ? 64'(bus_s.burst_ch_o) : 64'(bus.burst_ch_o);
  endfunction

  task automatic wait_start(input bit s, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = cur_start(s);
    end
    check_val({tag, "_start"}, 64'(seen), 64'd1);
  endtask

  task automatic do_burst(input bit s, input string tag, input logic exp_wr,
                          input logic [1:0] exp_ch, input logic [63:0] exp_addr);
    wait_start(s, tag);
    check_val({tag, "_wr"},   cur_wr(s),   64'(exp_wr));
    check_val({tag, "_ch"},   cur_ch(s),   64'(exp_ch));
    check_val({tag, "_addr"}, cur_addr(s), exp_addr);
    @(negedge clk);
    check_val({tag, "_pulse"},  64'(cur_start(s)), 64'd0);
    check_val({tag, "_stable"}, cur_addr(s), exp_addr);
    if (s) bus_s.burst_done_i = 1'b1;
    else   bus.burst_done_i   = 1'b1;
    @(negedge clk);
    bus_s.burst_done_i = 1'b0;
    bus.burst_done_i   = 1'b0;
  endtask

  task automatic count_starts(input bit s, input int ncyc, output int n_starts);
    n_starts = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (cur_start(s)) n_starts++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; phy = 1'b0;
    us = '0; ds = '0; us_s = '0; ds_s = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; phy = 1'b0;
    us = '0; ds = '0; us_s = '0; ds_s = '0;
    bus.burst_done_i = 1'b0; bus_s.burst_done_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_busy",  64'(busy), 64'd0);
    check_val("rst_start", 64'(bus.burst_start_o), 64'd0);
    check_val("rst_count", 64'(rc), 64'd0);
    check_val("rst_addr",  cur_addr(0), 64'd0);
    check_val("rst_wr",    cur_wr(0), 64'd0);
    check_val("rst_ch",    cur_ch(0), 64'd0);

    // Single write on ch0, held in INIT until calibration completes
    rst = 1'b0; us = 4'b0001;
    count_starts(0, 8, cnt);
    check_val("t1_init_hold", 64'(cnt), 64'd0);
    check_val("t1_init_busy", 64'(busy), 64'd0);
    phy = 1'b1;
    do_burst(0, "t1", 1'b1, 2'd0, 64'h0);
    us = '0;
    repeat (2) @(negedge clk);
    check_val("t1_cnt0", 64'(rc[19:0]), 64'd1);

    // Write round-robin across all four channels
    do_reset();
    phy = 1'b1; us = 4'b1111;
    do_burst(0, "t2_a", 1'b1, 2'd0, 64'h0);
    do_burst(0, "t2_b", 1'b1, 2'd1, 64'h2000_0000);
    do_burst(0, "t2_c", 1'b1, 2'd2, 64'h4000_0000);
    do_burst(0, "t2_d", 1'b1, 2'd3, 64'h6000_0000);
    do_burst(0, "t2_e", 1'b1, 2'd0, 64'h400);
    us = '0;
    repeat (2) @(negedge clk);
    check_val("t2_cnt0", 64'(rc[19:0]),  64'd2);
    check_val("t2_cnt1", 64'(rc[39:20]), 64'd1);
    check_val("t2_cnt2", 64'(rc[59:40]), 64'd1);
    check_val("t2_cnt3", 64'(rc[79:60]), 64'd1);

    // Direction alternation on ch1 (count 3, last direction read)
    do_reset();
    phy = 1'b1; us = 4'b0010;
    do_burst(0, "t3_w0", 1'b1, 2'd1, 64'h2000_0000);
    do_burst(0, "t3_w1", 1'b1, 2'd1, 64'h2000_0400);
    do_burst(0, "t3_w2", 1'b1, 2'd1, 64'h2000_0800);
    do_burst(0, "t3_w3", 1'b1, 2'd1, 64'h2000_0C00);
    us = '0; ds = 4'b0010;
    do_burst(0, "t3_r0", 1'b0, 2'd1, 64'h2000_0000);
    us = 4'b0010;
    do_burst(0, "t3_alt_w1", 1'b1, 2'd1, 64'h2000_1000);
    do_burst(0, "t3_alt_r1", 1'b0, 2'd1, 64'h2000_0400);
    do_burst(0, "t3_alt_w2", 1'b1, 2'd1, 64'h2000_1400);
    do_burst(0, "t3_alt_r2", 1'b0, 2'd1, 64'h2000_0800);
    us = '0; ds = '0;
    repeat (2) @(negedge clk);
    check_val("t3_cnt1", 64'(rc[39:20]), 64'd3);

    // Small ring: fill, full hold-off, drain, wrap
    us_s = 4'b0001;
    do_burst(1, "t4_w0", 1'b1, 2'd0, 64'h0);
    do_burst(1, "t4_w1", 1'b1, 2'd0, 64'h400);
    do_burst(1, "t4_w2", 1'b1, 2'd0, 64'h800);
    do_burst(1, "t4_w3", 1'b1, 2'd0, 64'hC00);
    count_starts(1, 20, cnt);
    check_val("t4_full_hold", 64'(cnt), 64'd0);
    check_val("t4_full_busy", 64'(busy_s), 64'd0);
    check_val("t4_full_cnt",  64'(rc_s[2:0]), 64'd4);
    us_s = '0; ds_s = 4'b0001;
    do_burst(1, "t4_r0", 1'b0, 2'd0, 64'h0);
    do_burst(1, "t4_r1", 1'b0, 2'd0, 64'h400);
    do_burst(1, "t4_r2", 1'b0, 2'd0, 64'h800);
    do_burst(1, "t4_r3", 1'b0, 2'd0, 64'hC00);
    ds_s = '0; us_s = 4'b0001;
    do_burst(1, "t4_wrap", 1'b1, 2'd0, 64'h0);
    us_s = '0;
    repeat (2) @(negedge clk);
    check_val("t4_wrap_cnt", 64'(rc_s[2:0]), 64'd1);

    // Reset in WAIT abandons the burst and re-requires calibration
    us = 4'b0001;
    wait_start(0, "t5_pre");
    us = '0;
    @(negedge clk);
    rst = 1'b1; phy = 1'b0;
    @(negedge clk);
    check_val("t5_rst_start", 64'(bus.burst_start_o), 64'd0);
    check_val("t5_rst_busy",  64'(busy), 64'd0);
    check_val("t5_rst_count", 64'(rc), 64'd0);
    check_val("t5_rst_addr",  cur_addr(0), 64'd0);
    rst = 1'b0; us = 4'b0001;
    count_starts(0, 10, cnt);
    check_val("t5_init_hold", 64'(cnt), 64'd0);
    phy = 1'b1;
    do_burst(0, "t5_after", 1'b1, 2'd0, 64'h0);
    us = '0;
    repeat (2) @(negedge clk);
    check_val("t5_cnt0", 64'(rc[19:0]), 64'd1);

    // Eligibility vanishes while in ARB: back to IDLE, no start
    us = 4'b0001;
    @(negedge clk);
    check_val("t6_arb_busy", 64'(busy), 64'd1);
    us = '0;
    count_starts(0, 6, cnt);
    check_val("t6_no_start", 64'(cnt), 64'd0);
    check_val("t6_idle_busy", 64'(busy), 64'd0);

    // Request in IDLE -> start exactly two cycles later
    us = 4'b0001;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (bus.burst_start_o) break;
    end
    check_val("t7_latency", 64'(lat), 64'd2);
    check_val("t7_addr", cur_addr(0), 64'h400);
    us = '0;
    @(negedge clk);
    bus.burst_done_i = 1'b1;
    @(negedge clk);
    bus.burst_done_i = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t7_cnt0", 64'(rc[19:0]), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
